hazard_unit: RTL and testbench

//  Data-hazard detector in ID. Drives the stall unit's request input and the EX operand-forwarding selects.

---
 rtl/hz_pkg.sv | 23 ++
 rtl/hz_track_reg.sv | 41 ++++
 rtl/hazard_unit.sv | 130 +++++++++++++
 tb/tb_hazard_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hz_pkg.sv
// Shared types and constants for the ID-stage data-hazard detector.
package hz_pkg;

    localparam int IDX_W = 5;

    localparam logic [IDX_W-1:0] ZERO_IDX = 5'd31;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] dest;
        logic             is_load;
    } hz_entry_t;

    // Encoding is shared with the EX operand mux.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    localparam hz_entry_t HZ_BUBBLE = '{valid: 1'b0, dest: 5'd0, is_load: 1'b0};

endpackage

// File: rtl/hz_track_reg.sv
// One in-flight destination entry: captures a new entry, takes a bubble, or holds.
module hz_track_reg
    import hz_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en_i,
    input  logic      load_i,
    input  hz_entry_t entry_i,
    output hz_entry_t entry_o
);

    hz_entry_t entry_q;
    hz_entry_t entry_d;

    // Next entry: advance only when the stage is enabled; a non-load advance inserts a bubble.
    always_comb begin
        entry_d = entry_q;
        if (en_i) begin
            if (load_i) begin
                entry_d = entry_i;
            end else begin
                entry_d = HZ_BUBBLE;
            end
        end else begin
            entry_d = entry_q;
        end
    end

    // Entry register.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= HZ_BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage RAW hazard detector: stall request, EX forwarding selects and stall-cycle counter.
// Macro HZ_FORWARD_EN enables forwarding; without it every in-flight dependence stalls.
module hazard_unit
    import hz_pkg::*;
#(
    parameter int unsigned               NREG     = 32,
    parameter logic [$clog2(NREG)-1:0]   ZERO_IDX = hz_pkg::ZERO_IDX,
    parameter int unsigned               CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ID_valid_inst,
    input  logic [$clog2(NREG)-1:0] ID_ra_idx,
    input  logic [$clog2(NREG)-1:0] ID_rb_idx,
    input  logic                    ID_ra_used,
    input  logic                    ID_rb_used,
    input  logic [$clog2(NREG)-1:0] ID_dest_reg_idx,
    input  logic                    ID_rd_mem,
    input  logic                    ST_id_ex_en,
    input  logic                    EX_take_branch,
    output logic                    HZ_stall,
    output logic [1:0]              HZ_fwd_a_sel,
    output logic [1:0]              HZ_fwd_b_sel,
    output logic [CNT_W-1:0]        HZ_stall_cnt
);

    hz_entry_t        ex_s;
    hz_entry_t        mem_s;
    hz_entry_t        id_entry_s;
    logic             ex_load_s;
    logic             ma_ex_s;
    logic             mb_ex_s;
    logic             ma_mem_s;
    logic             mb_mem_s;
    logic             stall_s;
    logic             mem_load_unused_s;
    fwd_sel_t         fwd_a_s;
    fwd_sel_t         fwd_b_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    function automatic logic src_match(input logic used, input logic [$clog2(NREG)-1:0] src,
                                       input hz_entry_t e);
        return used && (src != ZERO_IDX) && e.valid && (e.dest == src);
    endfunction

    assign id_entry_s = '{valid: 1'b1, dest: ID_dest_reg_idx, is_load: ID_rd_mem};
    assign ex_load_s  = ID_valid_inst & ~stall_s & ~EX_take_branch;

    hz_track_reg u_ex_entry (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ST_id_ex_en),
        .load_i  (ex_load_s),
        .entry_i (id_entry_s),
        .entry_o (ex_s)
    );

    hz_track_reg u_mem_entry (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ST_id_ex_en),
        .load_i  (1'b1),
        .entry_i (ex_s),
        .entry_o (mem_s)
    );

    // Load state of the MEM entry is not needed: a load in MEM is always forwardable.
    assign mem_load_unused_s = mem_s.is_load;

    assign ma_ex_s  = src_match(ID_ra_used, ID_ra_idx, ex_s);
    assign mb_ex_s  = src_match(ID_rb_used, ID_rb_idx, ex_s);
    assign ma_mem_s = src_match(ID_ra_used, ID_ra_idx, mem_s);
    assign mb_mem_s = src_match(ID_rb_used, ID_rb_idx, mem_s);

    // Stall request and forwarding selects; a squashed ID instruction never stalls.
    always_comb begin
        stall_s = 1'b0;
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
        if (ID_valid_inst) begin
`ifdef HZ_FORWARD_EN
            stall_s = ~EX_take_branch & ex_s.is_load & (ma_ex_s | mb_ex_s);
            if (ma_ex_s) begin
                fwd_a_s = FWD_EX;
            end else if (ma_mem_s) begin
                fwd_a_s = FWD_MEM;
            end else begin
                fwd_a_s = FWD_RF;
            end
            if (mb_ex_s) begin
                fwd_b_s = FWD_EX;
            end else if (mb_mem_s) begin
                fwd_b_s = FWD_MEM;
            end else begin
                fwd_b_s = FWD_RF;
            end
`else
            stall_s = ~EX_take_branch & (ma_ex_s | mb_ex_s | ma_mem_s | mb_mem_s);
`endif
        end else begin
            stall_s = 1'b0;
        end
    end

    // Saturating count of cycles that actually stalled the pipeline.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_s && ST_id_ex_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign HZ_stall     = stall_s;
    assign HZ_fwd_a_sel = fwd_a_s;
    assign HZ_fwd_b_sel = fwd_b_s;
    assign HZ_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed table, hand-written sequences, random vs model.
module tb_hazard_unit;

`ifdef HZ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        v_i, ua_i, ub_i, ld_i, en_i, br_i;
    logic [4:0]  ra_i, rb_i, dest_i;
    logic        HZ_stall;
    logic [1:0]  HZ_fwd_a_sel, HZ_fwd_b_sel;
    logic [31:0] HZ_stall_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk             (clk),
        .rst             (rst),
        .ID_valid_inst   (v_i),
        .ID_ra_idx       (ra_i),
        .ID_rb_idx       (rb_i),
        .ID_ra_used      (ua_i),
        .ID_rb_used      (ub_i),
        .ID_dest_reg_idx (dest_i),
        .ID_rd_mem       (ld_i),
        .ST_id_ex_en     (en_i),
        .EX_take_branch  (br_i),
        .HZ_stall        (HZ_stall),
        .HZ_fwd_a_sel    (HZ_fwd_a_sel),
        .HZ_fwd_b_sel    (HZ_fwd_b_sel),
        .HZ_stall_cnt    (HZ_stall_cnt)
    );

    typedef struct {
        bit r, v; int ra, rb; bit ua, ub; int dest; bit ld, en, br;
        bit e_stall; int e_a, e_b, e_cnt;
    } vec_t;

    // Reference model: in-flight writers, youngest first (0 = EX, 1 = MEM).
    typedef struct { bit v; int dest; bit ld; } ment_t;
    ment_t  st [2];
    longint mcnt;

    task automatic drive(input bit r, v, input int ra, rb, input bit ua, ub,
                         input int dest, input bit ld, en, br);
        rst = r; v_i = v; ra_i = 5'(ra); rb_i = 5'(rb); ua_i = ua; ub_i = ub;
        dest_i = 5'(dest); ld_i = ld; en_i = en; br_i = br;
    endtask

    task automatic check(input string nm, input bit es, input int ea, eb, ec);
        tests++;
        if (HZ_stall !== es || HZ_fwd_a_sel !== 2'(ea) || HZ_fwd_b_sel !== 2'(eb)
            || HZ_stall_cnt !== 32'(ec)) begin
            failed++;
            $display("FAIL %s: got stall=%0b a=%0d b=%0d cnt=%0d, want stall=%0b a=%0d b=%0d cnt=%0d",
                     nm, HZ_stall, HZ_fwd_a_sel, HZ_fwd_b_sel, HZ_stall_cnt, es, ea, eb, ec);
        end
    endtask

    task automatic cyc(input bit r, v, input int ra, rb, input bit ua, ub, input int dest,
                       input bit ld, en, br, input string nm, input bit es, input int ea, eb, ec);
        drive(r, v, ra, rb, ua, ub, dest, ld, en, br);
        @(negedge clk);
        check(nm, es, ea, eb, ec);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        st[0] = '{0, 0, 0};
        st[1] = '{0, 0, 0};
        mcnt  = 0;
    endtask

    function automatic int youngest(input bit used, input int src);
        if (!used || src == 31) return -1;
        for (int i = 0; i < 2; i++)
            if (st[i].v && st[i].dest == src) return i;
        return -1;
    endfunction

    function automatic int sel_of(input int y);
        if (!FWD) return 0;
        return (y == 0) ? 1 : (y == 1) ? 2 : 0;
    endfunction

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{0,1, 3, 0,1,0,31,0,1,0, 0, 0,0,0};
        vecs[1]  = '{0,1,31,31,1,1,31,1,1,0, 0, 0,0,0};
        vecs[2]  = '{0,1,31,31,1,1, 5,0,1,0, 0, 0,0,0};
        vecs[3]  = '{0,0, 5, 0,1,0, 0,0,1,0, 0, 0,0,0};
        vecs[4]  = '{0,1, 1, 2,1,1, 9,1,1,0, 0, 0,0,0};
        vecs[5]  = '{0,1, 9, 0,1,0,10,0,1,1, 0, FWD ? 1 : 0,0,0};
        vecs[6]  = '{0,1, 9, 0,1,0,11,0,0,0, !FWD, FWD ? 2 : 0,0,0};
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = '{0,0, 0, 0,0,0, 0,0,1,0, 0, 0,0,0};
        vecs[10] = '{0,1, 9, 9,1,1,12,0,1,0, 0, 0,0,0};

        do_reset();
        for (int i = 0; i < 11; i++)
            cyc(vecs[i].r, vecs[i].v, vecs[i].ra, vecs[i].rb, vecs[i].ua, vecs[i].ub,
                vecs[i].dest, vecs[i].ld, vecs[i].en, vecs[i].br, $sformatf("vec[%0d]", i),
                vecs[i].e_stall, vecs[i].e_a, vecs[i].e_b, vecs[i].e_cnt);

        // ALU dependences at distance one and two.
        do_reset();
        cyc(0,1,1,2,1,1,3,0,1,0, "add_r3", 0,0,0,0);
        if (FWD) begin
            cyc(0,1,3,2,1,1,4,0,1,0, "fwd_ex", 0,1,0,0);
            cyc(0,1,1,2,1,1,8,0,1,0, "fwd_gap", 0,0,0,0);
            cyc(0,1,1,4,1,1,9,0,1,0, "fwd_mem", 0,0,2,0);
            cyc(0,1,1,0,1,0,5,1,1,0, "ldq_r5", 0,0,0,0);
            cyc(0,1,5,2,1,1,6,0,1,0, "lu_stall", 1,1,0,0);
            cyc(0,1,5,2,1,1,6,0,1,0, "lu_release", 0,2,0,1);
            cyc(0,1,6,6,1,1,7,0,1,0, "lu_after", 0,1,1,1);
        end else begin
            cyc(0,1,3,2,1,1,4,0,1,0, "nf_stall1", 1,0,0,0);
            cyc(0,1,3,2,1,1,4,0,1,0, "nf_stall2", 1,0,0,1);
            cyc(0,1,3,2,1,1,4,0,1,0, "nf_release", 0,0,0,2);
            cyc(0,1,1,2,1,1,8,0,1,0, "nf_gap", 0,0,0,2);
            cyc(0,1,1,4,1,1,9,0,1,0, "nf_gap_stall", 1,0,0,2);
            cyc(0,1,1,4,1,1,9,0,1,0, "nf_gap_release", 0,0,0,3);
        end

        // Reset asserted while a load-use stall is pending.
        do_reset();
        cyc(0,1,1,0,1,0,5,1,1,0, "rst_ldq", 0,0,0,0);
        cyc(1,1,5,0,1,0,6,0,1,0, "rst_in_stall", 1,FWD ? 1 : 0,0,0);
        cyc(0,1,5,0,1,0,6,0,1,0, "rst_after", 0,0,0,0);

        // Random stimulus against the reference model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit r, v, ua, ub, ld, en, br, es;
            int ra, rb, dest, ya, yb;
            r    = ($urandom_range(0, 99) == 0);
            v    = ($urandom_range(0, 7) != 0);
            ra   = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 5));
            rb   = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 5));
            dest = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 5));
            ua   = ($urandom_range(0, 3) != 0);
            ub   = ($urandom_range(0, 3) != 0);
            ld   = ($urandom_range(0, 2) == 0);
            en   = ($urandom_range(0, 3) != 0);
            br   = ($urandom_range(0, 7) == 0);
            drive(r, v, ra, rb, ua, ub, dest, ld, en, br);
            ya = youngest(ua, ra);
            yb = youngest(ub, rb);
            if (FWD) es = v && !br && st[0].ld && (ya == 0 || yb == 0);
            else     es = v && !br && (ya >= 0 || yb >= 0);
            @(negedge clk);
            check($sformatf("rand[%0d]", n), es, v ? sel_of(ya) : 0, v ? sel_of(yb) : 0, int'(mcnt));
            if (r) begin
                st[0] = '{0, 0, 0};
                st[1] = '{0, 0, 0};
                mcnt  = 0;
            end else if (en) begin
                if (es && mcnt < 64'hFFFF_FFFF) mcnt++;
                st[1] = st[0];
                st[0] = (v && !es && !br) ? '{1, dest, ld} : '{0, 0, 0};
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
